// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the add_arbiter slice: parameter defaults,
// mode encodings and the requester-id width helper.
package add_arbiter_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int W_DEFAULT     = 8;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/add_arbiter_pipe_add.sv
// Two-stage registered adder: operand registers, a combinational W-bit add,
// and result registers that reload on every edge.
module pipe_add
    import add_arbiter_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W:0]   total;

    // Operands are captured only on a transfer so the result stage keeps
    // recomputing the last sum, which makes the outputs hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Unsigned add with one extra bit so wrap-around shows up as the carry.
    always_comb begin
        total = {1'b0, a_q} + {1'b0, b_q};
    end

    // Result stage reloads every edge with no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= total[W-1:0];
            cout <= total[W];
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates N_REQ requesters (round-robin or fixed priority) onto a shared
// two-stage adder and returns each result tagged with the owner's index.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*W-1:0]           a_in,
    input  logic [N_REQ*W-1:0]           b_in,
    input  logic                         mode,
    output logic [N_REQ-1:0]             gnt,
    output logic                         rsp_valid,
    output logic [id_width(N_REQ)-1:0]   rsp_id,
    output logic [W-1:0]                 rsp_sum,
    output logic                         rsp_cout,
    output logic                         busy
);

    localparam int IW = id_width(N_REQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] low_idx;
    logic [IW-1:0] high_idx;
    logic          high_found;
    logic          granted;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          s1_valid;
    logic [IW-1:0] s1_id;

    // Grant selection. Round-robin takes the lowest request at or above the
    // pointer, else wraps to the lowest request overall. Reset masks all grants.
    always_comb begin
        gnt        = '0;
        grant_idx  = '0;
        low_idx    = '0;
        high_idx   = '0;
        high_found = 1'b0;
        granted    = 1'b0;
        if (rst_n && (req != '0)) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req[i]) begin
                    low_idx = IW'(i);
                    if (IW'(i) >= ptr) begin
                        high_idx   = IW'(i);
                        high_found = 1'b1;
                    end
                end
            end
            if (mode == MODE_FIXED) begin
                grant_idx = low_idx;
            end else if (high_found) begin
                grant_idx = high_idx;
            end else begin
                grant_idx = low_idx;
            end
            granted        = 1'b1;
            gnt[grant_idx] = 1'b1;
        end
    end

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = sel_a | a_in[i*W +: W];
                sel_b = sel_b | b_in[i*W +: W];
            end
        end
    end

    // Pointer moves just past the winner in either mode, holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (granted) begin
            if (grant_idx == IW'(N_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Id/valid pipeline aligned with the adder stages; ids load only on a
    // transfer so rsp_id holds while no result is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            s1_valid  <= granted;
            if (granted) begin
                s1_id <= grant_idx;
            end
            rsp_valid <= s1_valid;
            rsp_id    <= s1_id;
        end
    end

    pipe_add #(.W(W)) u_pipe_add (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (granted),
        .a     (sel_a),
        .b     (sel_b),
        .sum   (rsp_sum),
        .cout  (rsp_cout)
    );

    assign busy = s1_valid | rsp_valid;

endmodule
